rs232_rx: RTL and testbench
===========================

RS232_RX -- requirements
Module: rs232_rx

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 115_200, line bit rate.
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rx  input  1  serial line, asynchronous to clk, idle high.
REQ-006 SHALL have port data  output  8  last received byte, LSB = first data bit.
REQ-007 SHALL have port valid  output  1  data holds an unconsumed byte.
REQ-008 SHALL have port ready  input  1  consumer accepts data when valid && ready at a rising edge.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse: byte completed while holding buffer full.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer, both flops reset to 1; all decisions use the synchronized value.
REQ-012 SHALL generate a 16x oversample tick every DIV = CLOCK_HZ/(16*BAUDRATE) clk cycles (integer, truncated; 27 at defaults); divider restarts at 0 on leaving IDLE.
REQ-013 SHALL implement states IDLE, START, DATA, STOP.
REQ-014 IDLE: on synchronized rx = 0, SHALL enter START with tick index 0.
REQ-015 START: at tick indices 7, 8, 9 SHALL sample rx; majority 0 -> continue to DATA at index 16; majority 1 -> glitch, return to IDLE, no output change.
REQ-016 DATA: each bit SHALL span 16 ticks, value = majority of samples at indices 7, 8, 9; bits shifted in LSB first; after bit 7 enter STOP.
REQ-017 STOP: at tick index 9 SHALL decide on majority; 1 -> byte complete, return to IDLE immediately (half-bit early, permits back-to-back frames).
REQ-018 STOP majority 0 SHALL pulse frame_err for one cycle, discard the byte, and stay in STOP until synchronized rx = 1, then enter IDLE.
REQ-019 On byte complete with valid = 0: data loaded and valid = 1 on the next clk edge.
REQ-020 valid SHALL stay 1 and data stable until the edge where ready = 1; valid clears that edge.
REQ-021 Byte complete with valid = 1 and ready = 0: overrun pulses one cycle, new byte dropped, old data/valid retained.
REQ-022 Byte complete in the same cycle as ready = 1 with valid = 1: new byte loaded, valid remains 1, no overrun.
REQ-023 ready while valid = 0 SHALL have no effect.
REQ-024 frame_err and overrun SHALL never both be 1 in the same cycle.

Reset
REQ-025 rst = 0 SHALL immediately force: state IDLE, divider and tick/bit counters 0, shift register 0, data = 0x00, valid = 0, frame_err = 0, overrun = 0, synchronizer flops = 1.
REQ-026 rst asserted mid-frame SHALL abort the frame with no output; after release the block waits in IDLE for the next falling edge, and a frame already in progress on rx is treated as a new start from its next low level.
REQ-027 Release of rst SHALL be glitch-free: no valid/frame_err/overrun pulse in the first cycle after release.

Verification
REQ-028 Behavioural RS232 model sends 0x55 at 115200 baud, ready held 1 -> valid pulses one cycle, data = 0x55, no frame_err/overrun.
REQ-029 Send 0xA3 then 0x0F back-to-back, ready = 0 until after second stop -> data = 0xA3, valid = 1, overrun pulses once; then ready = 1 -> valid clears, data stays 0xA3.
REQ-030 Send 0x81 with stop bit forced 0 for one bit time -> frame_err one-cycle pulse, valid stays 0; subsequent 0x42 received correctly.
REQ-031 rx low pulse of 3 oversample ticks (~80 clk) then high -> no output, FSM back in IDLE; following 0xFF received correctly.
REQ-032 rx data edges displaced +/-5 % of bit period (jitter on every bit of 0x3C) -> data = 0x3C, no errors.
REQ-033 Assert rst during bit 4 of 0xC6, release mid-frame, then send 0x27 after line idle for 1 bit time -> no output for aborted frame, data = 0x27 valid.

Source files
------------

// File: rtl/rs232_rx_if.sv
// rs232_rx_if: serial line input plus received-byte handshake and error pulses
interface rs232_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    modport master (output rx, ready, input data, valid, frame_err, overrun);
    modport slave  (input rx, ready, output data, valid, frame_err, overrun);
endinterface

// File: rtl/rs232_rx.sv
// rs232_rx: 16x oversampled 8N1 UART receiver with a one-byte holding buffer
module rs232_rx #(
    parameter int CLOCK_HZ = 50_000_000,
    parameter int BAUDRATE = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    rs232_rx_if.slave  bus
);
    localparam int DIV = CLOCK_HZ / (16 * BAUDRATE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q;
    logic          sync1_q, sync2_q;
    logic [DW-1:0] div_q;
    logic [3:0]    idx_q;
    logic [2:0]    bit_q;
    logic [1:0]    smp_q;
    logic [7:0]    shift_q, data_q;
    logic          valid_q, ferr_q, ovr_q, brk_q;
    logic          tick, maj, done;

    assign tick = (div_q == DW'(DIV - 1));
    assign maj  = (smp_q[0] & smp_q[1]) | (smp_q[0] & sync2_q) | (smp_q[1] & sync2_q);
    assign done = (state_q == STOP) && !brk_q && tick && (idx_q == 4'd9) && maj;

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;

    // two-flop synchronizer, idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.rx;
            sync2_q <= sync1_q;
        end
    end

    // frame FSM with oversample divider, mid-bit majority voting and output buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            idx_q   <= 4'd0;
            bit_q   <= 3'd0;
            smp_q   <= 2'b00;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
            div_q  <= (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
            if (tick) idx_q <= idx_q + 4'd1;
            if (tick && idx_q == 4'd7) smp_q[0] <= sync2_q;
            if (tick && idx_q == 4'd8) smp_q[1] <= sync2_q;
            case (state_q)
                IDLE: begin
                    idx_q <= 4'd0;
                    if (!sync2_q) state_q <= START;
                end
                START: begin
                    if (tick && idx_q == 4'd9 && maj) begin
                        state_q <= IDLE;
                    end else if (tick && idx_q == 4'd15) begin
                        state_q <= DATA;
                        bit_q   <= 3'd0;
                    end
                end
                DATA: begin
                    if (tick && idx_q == 4'd9) shift_q <= {maj, shift_q[7:1]};
                    if (tick && idx_q == 4'd15) begin
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= STOP;
                    end
                end
                STOP: begin
                    if (brk_q) begin
                        if (sync2_q) begin
                            brk_q   <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else if (tick && idx_q == 4'd9) begin
                        if (maj) begin
                            state_q <= IDLE;
                        end else begin
                            brk_q  <= 1'b1;
                            ferr_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (done) begin
                if (!valid_q || bus.ready) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (bus.ready) begin
                valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rs232_rx.sv
// tb_rs232_rx: table-driven and scoreboard checks of the UART receiver
module tb_rs232_rx;
    localparam int BT = 434;
    localparam int J  = 21;

    logic clk = 1'b0;
    logic rst = 1'b0;
    rs232_rx_if bus ();

    rs232_rx dut (.clk(clk), .rst(rst), .bus(bus));

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int ferr_n = 0;
    int ovr_n = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_e;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        bit         jit;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input bit jit);
        logic [9:0] lv;
        int e0, e1;
        lv = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            e0 = i * BT + ((jit && i > 0) ? ((i % 2) ? J : -J) : 0);
            e1 = (i + 1) * BT + ((jit && i < 9) ? (((i + 1) % 2) ? J : -J) : 0);
            bus.rx = lv[i];
            repeat (e1 - e0) @(posedge clk);
        end
        bus.rx = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (bus.valid && bus.ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'h0, bus.data}, 32'hffff_ffff);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rx_data", {24'h0, bus.data}, {24'h0, mon_e});
                end
            end
            if (bus.frame_err) ferr_n++;
            if (bus.overrun) ovr_n++;
            if (bus.frame_err || bus.overrun)
                check("err_exclusive", {31'h0, bus.frame_err & bus.overrun}, 32'h0);
        end
    end

    initial begin
        int f0, o0;
        vecs[0] = '{8'h55, 1'b1, 1'b0, 8'h55, 0};
        vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 0};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 8'h00, 0};
        vecs[3] = '{8'h81, 1'b0, 1'b0, 8'h00, 1};
        vecs[4] = '{8'h42, 1'b1, 1'b0, 8'h42, 0};
        bus.rx = 1'b1;
        bus.ready = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data", {24'h0, bus.data}, 32'h0);
        check("rst_valid", {31'h0, bus.valid}, 32'h0);
        check("rst_ferr", {31'h0, bus.frame_err}, 32'h0);
        check("rst_ovr", {31'h0, bus.overrun}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_pulses", {29'h0, bus.valid, bus.frame_err, bus.overrun}, 32'h0);
        repeat (BT) @(posedge clk);

        for (int v = 0; v < 5; v++) begin
            f0 = ferr_n;
            if (vecs[v].exp_ferr == 0) exp_q.push_back(vecs[v].exp_data);
            send(vecs[v].b, vecs[v].stop, vecs[v].jit);
            repeat (2 * BT) @(posedge clk);
            @(negedge clk);
            check("vec_drain", exp_q.size(), 32'h0);
            check("vec_ferr", ferr_n - f0, vecs[v].exp_ferr);
            check("vec_data", {24'h0, bus.data}, {24'h0, vecs[v].exp_data});
            check("vec_valid", {31'h0, bus.valid}, 32'h0);
        end

        @(posedge clk);
        bus.ready = 1'b0;
        o0 = ovr_n;
        f0 = ferr_n;
        send(8'hA3, 1'b1, 1'b0);
        send(8'h0F, 1'b1, 1'b0);
        repeat (BT) @(posedge clk);
        @(negedge clk);
        check("ovr_data", {24'h0, bus.data}, 32'hA3);
        check("ovr_valid", {31'h0, bus.valid}, 32'h1);
        check("ovr_count", ovr_n - o0, 32'h1);
        check("ovr_noferr", ferr_n - f0, 32'h0);
        exp_q.push_back(8'hA3);
        @(posedge clk);
        #2 bus.ready = 1'b1;
        repeat (4) @(negedge clk);
        check("ovr_drain", exp_q.size(), 32'h0);
        check("ovr_cleared", {31'h0, bus.valid}, 32'h0);
        check("ovr_data_kept", {24'h0, bus.data}, 32'hA3);

        @(posedge clk);
        f0 = ferr_n;
        bus.rx = 1'b0;
        repeat (80) @(posedge clk);
        bus.rx = 1'b1;
        repeat (BT) @(posedge clk);
        @(negedge clk);
        check("glitch_valid", {31'h0, bus.valid}, 32'h0);
        check("glitch_ferr", ferr_n - f0, 32'h0);
        check("glitch_data", {24'h0, bus.data}, 32'hA3);
        exp_q.push_back(8'hFF);
        @(posedge clk);
        send(8'hFF, 1'b1, 1'b0);
        repeat (2 * BT) @(posedge clk);
        @(negedge clk);
        check("glitch_drain", exp_q.size(), 32'h0);
        check("glitch_next", {24'h0, bus.data}, 32'hFF);

        @(posedge clk);
        fork
            send(8'hC6, 1'b1, 1'b0);
            begin
                repeat (5 * BT + BT / 2) @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                repeat (3) @(negedge clk);
                check("abort_data", {24'h0, bus.data}, 32'h0);
                check("abort_valid", {31'h0, bus.valid}, 32'h0);
                repeat (2 * BT - 5) @(posedge clk);
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check("abort_rel", {29'h0, bus.valid, bus.frame_err, bus.overrun}, 32'h0);
            end
        join
        f0 = ferr_n;
        o0 = ovr_n;
        repeat (BT) @(posedge clk);
        @(negedge clk);
        check("abort_none", {31'h0, bus.valid}, 32'h0);
        exp_q.push_back(8'h27);
        @(posedge clk);
        send(8'h27, 1'b1, 1'b0);
        repeat (2 * BT) @(posedge clk);
        @(negedge clk);
        check("abort_drain", exp_q.size(), 32'h0);
        check("abort_next", {24'h0, bus.data}, 32'h27);
        check("abort_errs", (ferr_n - f0) + (ovr_n - o0), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
